// File: rtl/ycr_sleep_req_if.sv
// Sleep/wake handshake bundle between core, sleep initiator and source clock gate.
// The slave modport is the initiator side; master drives core requests and gate status.
interface ycr_sleep_req_if #(
    parameter int CNT_W = 16
);
    logic             sleep_req;
    logic             bus_busy;
    logic [2:0]       cfg_mode;
    logic             wakeup;
    logic             clk_enb;
    logic             dst_idle;
    logic             sleep_ack;
    logic             sleep_nack;
    logic             wake_done;
    logic             wake_err;
    logic             sleeping;
    logic [CNT_W-1:0] sleep_cnt;

    modport master (
        output sleep_req, bus_busy, cfg_mode, wakeup, clk_enb,
        input  dst_idle, sleep_ack, sleep_nack, wake_done, wake_err, sleeping, sleep_cnt
    );

    modport slave (
        input  sleep_req, bus_busy, cfg_mode, wakeup, clk_enb,
        output dst_idle, sleep_ack, sleep_nack, wake_done, wake_err, sleeping, sleep_cnt
    );
endinterface

// File: rtl/ycr_sleep_req.sv
// Core-side sleep/wake initiator for the source clock gate: drains the bus, raises a
// registered dst_idle, then confirms the wake-up and reports the sleep duration.
module ycr_sleep_req #(
    parameter int QUIESCE_CYCLES = 4,
    parameter int CNT_W          = 16,
    parameter int TO_W           = 8
) (
    input  logic            clk_in,
    input  logic            reset_n,
    ycr_sleep_req_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    // DRAIN is entered with qcnt cleared; QUIESCE_CYCLES+1 idle samples place the
    // dst_idle rising edge at T+QUIESCE_CYCLES+1 after the sampling edge T.
    localparam logic [3:0] Q_LAST = 4'(QUIESCE_CYCLES);

    state_t           state_r;
    logic [3:0]       qcnt_r;
    logic [TO_W-1:0]  tcnt_r;
    logic             dst_idle_r;
    logic             sleep_ack_r;
    logic             sleep_nack_r;
    logic             wake_done_r;
    logic             wake_err_r;
    logic             sleeping_r;
    logic [CNT_W-1:0] sleep_cnt_r;
    logic             gating_s;

    function automatic logic is_gating(input logic [2:0] mode);
        return (mode >= 3'd1) && (mode <= 3'd4);
    endfunction

    assign gating_s = is_gating(bus.cfg_mode);

    // Handshake FSM with all outputs registered
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            qcnt_r       <= 4'd0;
            tcnt_r       <= {TO_W{1'b0}};
            dst_idle_r   <= 1'b0;
            sleep_ack_r  <= 1'b0;
            sleep_nack_r <= 1'b0;
            wake_done_r  <= 1'b0;
            wake_err_r   <= 1'b0;
            sleeping_r   <= 1'b0;
            sleep_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            sleep_ack_r  <= 1'b0;
            sleep_nack_r <= 1'b0;
            wake_done_r  <= 1'b0;
            wake_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.sleep_req) begin
                        if (gating_s) begin
                            state_r <= ST_DRAIN;
                            qcnt_r  <= 4'd0;
                        end else begin
                            sleep_nack_r <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!gating_s) begin
                        state_r      <= ST_IDLE;
                        sleep_nack_r <= 1'b1;
                    end else if (bus.bus_busy) begin
                        qcnt_r <= 4'd0;
                    end else if (qcnt_r == Q_LAST) begin
                        state_r     <= ST_SLEEP;
                        dst_idle_r  <= 1'b1;
                        sleep_ack_r <= 1'b1;
                        sleeping_r  <= 1'b1;
                        sleep_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        qcnt_r <= qcnt_r + 4'd1;
                    end
                end
                ST_SLEEP: begin
                    if (sleep_cnt_r != {CNT_W{1'b1}}) begin
                        sleep_cnt_r <= sleep_cnt_r + CNT_W'(1);
                    end
                    // Leaving gating mode is a software escape and wakes like an IRQ would
                    if (bus.wakeup || !gating_s) begin
                        state_r    <= ST_WAKE;
                        dst_idle_r <= 1'b0;
                        tcnt_r     <= {TO_W{1'b0}};
                    end
                end
                ST_WAKE: begin
                    if (bus.clk_enb) begin
                        state_r     <= ST_IDLE;
                        wake_done_r <= 1'b1;
                        sleeping_r  <= 1'b0;
                    end else if (tcnt_r == {TO_W{1'b1}}) begin
                        state_r    <= ST_IDLE;
                        wake_err_r <= 1'b1;
                        sleeping_r <= 1'b0;
                    end else begin
                        tcnt_r <= tcnt_r + TO_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dst_idle_r <= 1'b0;
                    sleeping_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dst_idle   = dst_idle_r;
    assign bus.sleep_ack  = sleep_ack_r;
    assign bus.sleep_nack = sleep_nack_r;
    assign bus.wake_done  = wake_done_r;
    assign bus.wake_err   = wake_err_r;
    assign bus.sleeping   = sleeping_r;
    assign bus.sleep_cnt  = sleep_cnt_r;

endmodule

// File: tb/tb_ycr_sleep_req.sv
// Directed self-checking bench for ycr_sleep_req with hand-computed expectations.
module tb_ycr_sleep_req;

    logic clk_in;
    logic reset_n;
    int   errors;
    int   checks;

    ycr_sleep_req_if #(.CNT_W(16)) bus ();

    ycr_sleep_req #(
        .QUIESCE_CYCLES(4),
        .CNT_W(16),
        .TO_W(8)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] all_outs();
        return {bus.dst_idle, bus.sleep_ack, bus.sleep_nack, bus.wake_done,
                bus.wake_err, bus.sleeping, bus.sleep_cnt};
    endfunction

    initial begin
        logic early;
        errors = 0;
        checks = 0;
        reset_n       = 1'b0;
        bus.sleep_req = 1'b0;
        bus.bus_busy  = 1'b0;
        bus.cfg_mode  = 3'd1;
        bus.wakeup    = 1'b0;
        bus.clk_enb   = 1'b1;

        ticks(3);
        check("reset_outputs", 32'(all_outs()), 32'd0);
        reset_n = 1'b1;
        ticks(2);
        check("idle_outputs", 32'(all_outs()), 32'd0);

        // Mode 1 sleep with the bus quiet: rise at T+5, then sleep 100 cycles
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        early = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            early = early | bus.dst_idle | bus.sleep_ack;
        end
        check("latency_no_early_rise", 32'(early), 32'd0);
        tick();
        check("latency_dst_idle", 32'(bus.dst_idle), 32'd1);
        check("latency_sleep_ack", 32'(bus.sleep_ack), 32'd1);
        check("latency_sleeping", 32'(bus.sleeping), 32'd1);
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        check("ack_one_cycle", 32'(bus.sleep_ack), 32'd0);
        check("sleep_cnt_1", 32'(bus.sleep_cnt), 32'd1);
        ticks(98);
        check("sleep_cnt_99", 32'(bus.sleep_cnt), 32'd99);
        bus.clk_enb = 1'b0;
        bus.wakeup  = 1'b1;
        tick();
        bus.wakeup = 1'b0;
        check("wake_dst_idle_low", 32'(bus.dst_idle), 32'd0);
        check("wake_sleeping", 32'(bus.sleeping), 32'd1);
        check("wake_cnt_100", 32'(bus.sleep_cnt), 32'd100);
        ticks(3);
        check("wake_no_early_done", 32'(bus.wake_done), 32'd0);
        bus.clk_enb = 1'b1;
        tick();
        check("wake_done_pulse", 32'(bus.wake_done), 32'd1);
        check("wake_sleeping_low", 32'(bus.sleeping), 32'd0);
        tick();
        check("wake_done_one_cycle", 32'(bus.wake_done), 32'd0);
        check("sleep_cnt_held", 32'(bus.sleep_cnt), 32'd100);
        bus.wakeup = 1'b1;
        tick();
        bus.wakeup = 1'b0;
        ticks(2);
        check("wakeup_in_idle_ignored", 32'({bus.dst_idle, bus.sleeping}), 32'd0);

        // Mode 2 with bus busy on DRAIN cycles 2 and 3
        bus.cfg_mode  = 3'd2;
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        tick();
        bus.bus_busy = 1'b1;
        ticks(2);
        bus.bus_busy = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            early = early | bus.dst_idle | bus.sleep_ack;
        end
        check("busy_no_early_rise", 32'(early), 32'd0);
        tick();
        check("busy_dst_idle", 32'(bus.dst_idle), 32'd1);
        check("busy_sleep_ack", 32'(bus.sleep_ack), 32'd1);
        // Software escape: mode leaves gating while asleep
        bus.cfg_mode = 3'd0;
        tick();
        check("escape_dst_idle_low", 32'(bus.dst_idle), 32'd0);
        check("escape_sleeping", 32'(bus.sleeping), 32'd1);
        tick();
        check("escape_wake_done", 32'(bus.wake_done), 32'd1);

        // Rejected requests in mode 0 and mode 5
        bus.cfg_mode  = 3'd0;
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        check("nack_mode0", 32'({bus.sleep_nack, bus.dst_idle}), 32'd2);
        tick();
        check("nack_mode0_one_cycle", 32'(bus.sleep_nack), 32'd0);
        bus.cfg_mode  = 3'd5;
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        check("nack_mode5", 32'({bus.sleep_nack, bus.dst_idle}), 32'd2);

        // Mode 1 -> 0 during DRAIN aborts, then no sleep without a new request
        bus.cfg_mode  = 3'd1;
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        tick();
        bus.cfg_mode = 3'd0;
        tick();
        check("drain_abort_nack", 32'(bus.sleep_nack), 32'd1);
        bus.cfg_mode = 3'd1;
        ticks(6);
        check("drain_abort_idle", 32'({bus.dst_idle, bus.sleeping}), 32'd0);

        // Wake timeout with clk_enb held low
        bus.clk_enb   = 1'b0;
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        ticks(5);
        check("to_sleep_dst_idle", 32'(bus.dst_idle), 32'd1);
        bus.wakeup = 1'b1;
        tick();
        bus.wakeup = 1'b0;
        early = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            early = early | bus.wake_err;
        end
        check("to_no_early_err", 32'(early), 32'd0);
        tick();
        check("to_wake_err", 32'(bus.wake_err), 32'd1);
        check("to_sleeping_low", 32'(bus.sleeping), 32'd0);
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        ticks(5);
        check("to_new_req_accepted", 32'(bus.dst_idle), 32'd1);

        // Asynchronous reset while asleep
        ticks(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(all_outs()), 32'd0);
        ticks(2);
        reset_n = 1'b1;
        tick();
        bus.sleep_req = 1'b1;
        tick();
        bus.sleep_req = 1'b0;
        ticks(5);
        check("post_reset_sleep", 32'({bus.dst_idle, bus.sleep_ack}), 32'd3);
        bus.wakeup = 1'b1;
        tick();
        bus.wakeup = 1'b0;
        check("post_reset_wake", 32'(bus.dst_idle), 32'd0);
        bus.clk_enb = 1'b1;
        tick();
        check("post_reset_wake_done", 32'(bus.wake_done), 32'd1);
        check("post_reset_cnt", 32'(bus.sleep_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
